freq_meter_1s: RTL and testbench
================================

FREQ_METER_1S -- requirements
Module: freq_meter_1s

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the clk frequency in Hz and the gate length in clk cycles.
REQ-002 SHALL have parameter CNT_W, default 26, meaning the width of the edge counter and the result.
REQ-003 SHALL have port clk, input, 1, the single system clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have port en, input, 1: 1 runs continuous measurement, 0 holds the block in IDLE.
REQ-006 SHALL have port sig_in, input, 1, the signal under test, asynchronous to clk.
REQ-007 SHALL have port freq_hz, output, CNT_W, the rising-edge count of the last completed gate window.
REQ-008 SHALL have port freq_valid, output, 1, a one-cycle pulse when freq_hz updates.
REQ-009 SHALL have port ovf, output, 1, set when the last completed window saturated.
REQ-010 SHALL have port busy, output, 1, high in states ARM and GATE.

Function
REQ-011 SHALL pass sig_in through a 2-flop synchronizer, then a rising-edge detector (sync current = 1, sync previous = 0); edge_now is valid 3 clk after the sig_in transition.
REQ-012 SHALL implement the FSM IDLE -> ARM -> GATE -> GATE (continuous); en = 0 in any state forces IDLE on the next clk.
REQ-013 SHALL go IDLE -> ARM on en = 1 and SHALL remain in ARM exactly 2 cycles, ignoring edge_now, to flush stale synchronizer data.
REQ-014 SHALL run gate_cnt 0..CLK_HZ-1 in GATE, incrementing every cycle, and SHALL add edge_now to edge_cnt every GATE cycle.
REQ-015 SHALL, at gate_cnt = CLK_HZ-1, register freq_hz = edge_cnt + edge_now (saturated), pulse freq_valid the next cycle, clear edge_cnt, and wrap gate_cnt to 0 with no lost cycle between windows.
REQ-016 SHALL saturate edge_cnt at 2^CNT_W-1 and set an internal sat flag; ovf SHALL be loaded from sat with each result, and sat SHALL clear with the window.
REQ-017 SHALL hold freq_hz and ovf between results, including through IDLE; leaving GATE early SHALL discard the partial window with no freq_valid.
REQ-018 SHALL measure correctly for input rates below CLK_HZ/2; higher rates are out of scope, with no behaviour guaranteed.
REQ-019 SHALL keep gate_cnt ceil(log2(CLK_HZ)) bits wide, independent of CNT_W.

Reset
REQ-020 SHALL, on rst = 1 at a clk edge, set state IDLE, gate_cnt 0, edge_cnt 0, sat 0, synchronizer flops 0, freq_hz 0, freq_valid 0, ovf 0, busy 0.
REQ-021 SHALL give rst priority over en and over a terminal-count event in the same cycle; a window in progress SHALL be discarded.
REQ-022 SHALL, after rst release with en = 1, enter ARM on the first clk and produce the first freq_valid exactly 2 + CLK_HZ + 1 cycles later.

Structure
REQ-023 SHALL place state encodings (IDLE, ARM, GATE) and the default CLK_HZ/CNT_W values in shared package/header freq_meter_pkg.
REQ-024 SHALL implement synchronizer plus edge detector as sub-module sync_edge_rise (ports clk, rst, d, rise), reusable for other async inputs.
REQ-025 SHALL be implementable in 120-400 lines of RTL, with no clock gating and no derived clocks, and sig_in SHALL NOT be used as a clock.

Verification (CLK_HZ = 100, CNT_W = 26 unless stated)
REQ-026 SHALL test sig_in period 10 clk, en = 1 -> first freq_valid at cycle 103 after reset release, freq_hz = 10, ovf = 0, then every 100 cycles.
REQ-027 SHALL test sig_in constant 0, then constant 1 -> freq_hz = 0 each window (a level produces no edges after ARM).
REQ-028 SHALL test sig_in toggling every clk (period 2) -> freq_hz = 50 each window, no window-boundary edge lost or double-counted.
REQ-029 SHALL test en dropped at gate_cnt = 50, then raised 5 cycles later -> no freq_valid for the aborted window, freq_hz holds the previous value, next result arrives 103 cycles after en rises.
REQ-030 SHALL test rst pulsed for 1 cycle at gate_cnt = 70 -> all outputs 0 next cycle, then a normal restart per REQ-022.
REQ-031 SHALL test CNT_W = 4 with sig_in period 5 (20 edges/window) -> freq_hz = 15, ovf = 1; the next window at period 10 -> freq_hz = 10, ovf = 0.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the 1-second gated frequency meter: FSM encoding,
// default clock/counter sizing and the gate-counter width helper.
package freq_meter_pkg;

  localparam int unsigned CLK_HZ_DEF = 50_000_000;
  localparam int unsigned CNT_W_DEF  = 26;

  // Settling cycles spent in ARM before counting, so stale synchronizer data never lands in a window.
  localparam int unsigned ARM_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } fm_state_e;

  function automatic int unsigned gate_w(input int unsigned hz);
    return (hz < 32'd2) ? 32'd1 : int'($clog2(hz));
  endfunction

endpackage

// File: rtl/sync_edge_rise.sv
// Two-flop synchronizer plus rising-edge detector for one asynchronous input;
// rise is high for one clk cycle per synchronized 0->1 transition.
module sync_edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rise = r_sync & ~r_prev;

endmodule

// File: rtl/freq_meter_1s.sv
// Gated frequency meter: counts rising edges of sig_in over back-to-back
// windows of CLK_HZ clk cycles and reports each window's count.
//
//   state | meaning
//   IDLE  | disabled, results held
//   ARM   | ARM_CYCLES settling cycles, edges ignored
//   GATE  | counting, windows run back to back
module freq_meter_1s
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_hz,
  output logic             freq_valid,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned      GATE_W    = gate_w(CLK_HZ);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(CLK_HZ - 1);
  localparam int unsigned      ARM_W     = (ARM_CYCLES < 2) ? 1 : $clog2(ARM_CYCLES);
  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  fm_state_e         r_state;
  fm_state_e         w_state_nxt;
  logic [ARM_W-1:0]  r_arm_cnt;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_sat;
  logic [CNT_W-1:0]  r_freq_hz;
  logic              r_ovf;
  logic              r_freq_pend;
  logic              r_freq_valid;

  logic              w_rise;
  logic              w_counting;
  logic              w_gate_tc;
  logic              w_edge_add;
  logic              w_at_max;
  logic [CNT_W-1:0]  w_edge_nxt;
  logic              w_sat_nxt;

  sync_edge_rise u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (w_rise)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (en) w_state_nxt = ARM;
      end
      ARM: begin
        if (!en)                         w_state_nxt = IDLE;
        else if (r_arm_cnt == ARM_LAST)  w_state_nxt = GATE;
      end
      GATE: begin
        if (!en) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A window only advances while enabled; dropping en mid-window throws it away.
  always_comb begin
    w_counting = (r_state == GATE) && en;
    w_gate_tc  = w_counting && (r_gate_cnt == GATE_LAST);
    w_edge_add = w_counting && w_rise;
    w_at_max   = (r_edge_cnt == CNT_MAX);
    w_edge_nxt = r_edge_cnt;
    w_sat_nxt  = r_sat;
    if (w_edge_add) begin
      if (w_at_max) w_sat_nxt  = 1'b1;
      else          w_edge_nxt = r_edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_arm_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARM) r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      else                r_arm_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else if (w_gate_tc || !w_counting) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_gate_cnt <= r_gate_cnt + GATE_W'(1);
      r_edge_cnt <= w_edge_nxt;
      r_sat      <= w_sat_nxt;
    end
  end

  // The result register loads on the terminal cycle; the valid strobe trails it by one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_freq_hz    <= '0;
      r_ovf        <= 1'b0;
      r_freq_pend  <= 1'b0;
      r_freq_valid <= 1'b0;
    end else begin
      r_freq_pend  <= w_gate_tc;
      r_freq_valid <= r_freq_pend;
      if (w_gate_tc) begin
        r_freq_hz <= w_edge_nxt;
        r_ovf     <= w_sat_nxt;
      end
    end
  end

  assign freq_hz    = r_freq_hz;
  assign freq_valid = r_freq_valid;
  assign ovf        = r_ovf;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_freq_meter_1s.sv
// Scoreboard bench: two meters (wide and 4-bit counters) share one randomized
// stimulus; a sample-level edge/window model predicts every result and pulse.
module tb_freq_meter_1s;

  localparam int     P    = 100;
  localparam int     WA   = 26;
  localparam int     WB   = 4;
  localparam longint MAXA = (64'd1 << WA) - 1;
  localparam longint MAXB = (64'd1 << WB) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          sig_in = 1'b0;
  logic [WA-1:0] a_freq;
  logic          a_valid, a_ovf, a_busy;
  logic [WB-1:0] b_freq;
  logic          b_valid, b_ovf, b_busy;

  freq_meter_1s #(.CLK_HZ(P), .CNT_W(WA)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_hz(a_freq), .freq_valid(a_valid), .ovf(a_ovf), .busy(a_busy)
  );

  freq_meter_1s #(.CLK_HZ(P), .CNT_W(WB)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_hz(b_freq), .freq_valid(b_valid), .ovf(b_ovf), .busy(b_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     idx;
    longint fa;
    bit     oa;
    longint fb;
    bit     ob;
  } exp_t;

  exp_t   q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     k = 0;
  int     per = 10;
  bit     lvl = 1'b0;
  int     ph = 0;

  // model state
  bit     h1, h2, h3, xk, rise, running, pend;
  int     s_idx, acc, off;
  int     m_gate = -1;
  longint mdl_fa = 0, mdl_fb = 0;
  bit     mdl_oa = 1'b0, mdl_ob = 1'b0, mdl_busy = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, k);
    end
  endtask

  // Reference: a window is P consecutive sampled edges starting 3 edges after
  // en is first seen; an input rise counts on the 3rd edge after it is driven.
  initial forever begin
    @(posedge clk);
    k++;
    rise = h2 & ~h3;
    xk   = rst ? 1'b0 : sig_in;
    h3 = h2; h2 = h1; h1 = xk;
    if (pend && !rst) q.push_back('{k, mdl_fa, mdl_oa, mdl_fb, mdl_ob});
    pend = 1'b0;
    if (rst) begin
      running = 1'b0; acc = 0;
      mdl_fa = 0; mdl_fb = 0; mdl_oa = 1'b0; mdl_ob = 1'b0;
    end else if (!en) begin
      running = 1'b0; acc = 0;
    end else if (!running) begin
      running = 1'b1; s_idx = k; acc = 0;
    end else begin
      off = k - s_idx;
      if (off >= 3) begin
        acc += int'(rise);
        if ((off - 2) % P == 0) begin
          mdl_fa = (acc > MAXA) ? MAXA : acc;
          mdl_oa = (acc > MAXA);
          mdl_fb = (acc > MAXB) ? MAXB : acc;
          mdl_ob = (acc > MAXB);
          pend = 1'b1;
          acc = 0;
        end
      end
    end
    mdl_busy = running;
    m_gate = (running && (k - s_idx) >= 2) ? (k - s_idx - 2) % P : -1;
  end

  initial forever begin
    @(negedge clk);
    if (per == 0) sig_in = lvl;
    else begin
      ph = (ph + 1) % per;
      sig_in = (ph < per / 2);
    end
  end

  initial forever begin : monitor
    bit   exp_now;
    exp_t e;
    @(negedge clk);
    exp_now = (q.size() > 0) && (q[0].idx == k);
    chk("a_valid", a_valid, exp_now);
    chk("b_valid", b_valid, exp_now);
    if (exp_now) begin
      e = q.pop_front();
      chk("a_result", a_freq, e.fa);
      chk("a_result_ovf", a_ovf, e.oa);
      chk("b_result", b_freq, e.fb);
      chk("b_result_ovf", b_ovf, e.ob);
    end
    chk("a_freq_hold", a_freq, mdl_fa);
    chk("a_ovf_hold", a_ovf, mdl_oa);
    chk("b_freq_hold", b_freq, mdl_fb);
    chk("b_ovf_hold", b_ovf, mdl_ob);
    chk("a_busy", a_busy, mdl_busy);
    chk("b_busy", b_busy, mdl_busy);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gate(input int g);
    for (int i = 0; i < 4 * P; i++) begin
      @(negedge clk);
      if (m_gate == g) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_gate: gate position %0d never reached, expected %0d", m_gate, g);
  endtask

  task automatic finish_run();
    cyc(5);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: cycle budget exhausted at %0d, expected completion", k);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    cyc(3);
    rst = 1'b0;
    en  = 1'b1;
    cyc(3 * P + 10);

    per = 0; lvl = 1'b0;
    cyc(2 * P + 5);
    en = 1'b0; lvl = 1'b1;
    cyc(5);
    en = 1'b1;
    cyc(2 * P + 10);

    per = 2;
    cyc(3 * P + 10);

    per = 10;
    wait_gate(50);
    en = 1'b0;
    cyc(5);
    en = 1'b1;
    cyc(P + 10);

    wait_gate(70);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2 * P + 10);

    wait_gate(P - 1);
    per = 5;
    cyc(P);
    per = 10;
    cyc(2 * P + 10);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        per = 0;
        lvl = 1'($urandom_range(0, 1));
      end else begin
        per = $urandom_range(2, 40);
      end
      cyc($urandom_range(50, 250));
      case ($urandom_range(0, 3))
        0: begin en = 1'b0; cyc($urandom_range(1, 8)); en = 1'b1; end
        1: begin rst = 1'b1; cyc(1); rst = 1'b0; end
        default: ;
      endcase
    end
    cyc(2 * P + 10);
    finish_run();
  end

endmodule
